dot_product_loader: RTL

Streaming front-end for `dot_product_2`. It accepts signed element pairs one per cycle over a valid/ready handshake and assembles them into two packed N-element vectors. Each finished vector pair is presented to the dot-product stage with a valid/ready handshake. A ping-pong pair of buffers lets a new vector load while the previous one waits to be consumed.

---
 rtl/dot_product_pkg.sv | 18 +
 rtl/dot_product_bank.sv | 71 +++++++
 rtl/dot_product_loader.sv | 102 ++++++++++
 3 files changed

// File: rtl/dot_product_pkg.sv
// Shared defaults, bank state encoding and length-width helper for the
// dot-product loader and its buffer banks.
package dot_product_pkg;

    localparam int DEFAULT_N  = 2;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_t;

    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dot_product_bank.sv
// One ping-pong buffer: N element pairs, a length and a fill state. The bank
// returns to all-zero on free, so short vectors read back zero-padded.
module dot_product_bank
    import dot_product_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int DW = DEFAULT_DW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_we,
    input  logic [$clog2(N)-1:0]      i_idx,
    input  logic [DW-1:0]             i_a,
    input  logic [DW-1:0]             i_b,
    input  logic                      i_close,
    input  logic [len_width(N)-1:0]   i_len,
    input  logic                      i_free,
    output logic [N*DW-1:0]           o_vec_a,
    output logic [N*DW-1:0]           o_vec_b,
    output logic [len_width(N)-1:0]   o_len,
    output logic                      o_full
);

    localparam int LW = len_width(N);

    logic [DW-1:0] r_a [N];
    logic [DW-1:0] r_b [N];
    logic [LW-1:0] r_len;
    bank_state_t   r_state;

    // A close always arrives together with the write of the closing element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_len   <= '0;
            for (int i = 0; i < N; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (i_free) begin
            r_state <= EMPTY;
            r_len   <= '0;
            for (int i = 0; i < N; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (i_we) begin
            r_a[i_idx] <= i_a;
            r_b[i_idx] <= i_b;
            if (i_close) begin
                r_state <= FULL;
                r_len   <= i_len;
            end else begin
                r_state <= FILLING;
            end
        end
    end

    always_comb begin
        o_vec_a = '0;
        o_vec_b = '0;
        for (int i = 0; i < N; i++) begin
            o_vec_a[i*DW +: DW] = r_a[i];
            o_vec_b[i*DW +: DW] = r_b[i];
        end
    end

    assign o_len  = r_len;
    assign o_full = (r_state == FULL);

endmodule

// File: rtl/dot_product_loader.sv
// Streaming front-end for dot_product_2: packs element pairs into two N-wide
// vectors using two ping-pong banks so loading overlaps with draining.
module dot_product_loader
    import dot_product_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int DW = DEFAULT_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_a,
    input  logic [DW-1:0]          in_b,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*DW-1:0]        out_vec1,
    output logic [N*DW-1:0]        out_vec2,
    output logic [$clog2(N+1)-1:0] out_len,
    output logic                   len_err
);

    localparam int CW = $clog2(N);
    localparam int LW = len_width(N);

    logic [CW-1:0]   r_cnt;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic            r_len_err;

    logic [1:0]      w_full;
    logic [N*DW-1:0] w_vec_a [2];
    logic [N*DW-1:0] w_vec_b [2];
    logic [LW-1:0]   w_len   [2];
    logic            w_accept;
    logic            w_at_end;
    logic            w_close;
    logic            w_drain;
    logic [LW-1:0]   w_close_len;

    // Ready depends only on bank state, never on out_ready.
    assign in_ready    = !w_full[r_wr_bank];
    assign w_accept    = in_valid && in_ready;
    assign w_at_end    = (r_cnt == CW'(N - 1));
    assign w_close     = w_accept && (in_last || w_at_end);
    assign w_close_len = LW'(r_cnt) + LW'(1);
    assign out_valid   = w_full[r_rd_bank];
    assign w_drain     = out_valid && out_ready;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        dot_product_bank #(
            .N  (N),
            .DW (DW)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_accept && (r_wr_bank == 1'(g))),
            .i_idx   (r_cnt),
            .i_a     (in_a),
            .i_b     (in_b),
            .i_close (w_close),
            .i_len   (w_close_len),
            .i_free  (w_drain && (r_rd_bank == 1'(g))),
            .o_vec_a (w_vec_a[g]),
            .o_vec_b (w_vec_b[g]),
            .o_len   (w_len[g]),
            .o_full  (w_full[g])
        );
    end

    assign out_vec1 = w_vec_a[r_rd_bank];
    assign out_vec2 = w_vec_b[r_rd_bank];
    assign out_len  = w_len[r_rd_bank];
    assign len_err  = r_len_err;

    // A vector that fills all N slots without in_last still closes, but is flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_cnt     <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_at_end && !in_last) begin
                    r_len_err <= 1'b1;
                end
            end
            if (w_drain) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

endmodule
